// File: rtl/insn_prefetch_buffer.sv
`default_nettype none
// =============================================================================
// Module   : insn_prefetch_buffer
// Brief    : OBI instruction prefetcher with in-order response FIFO and
//            redirect discard. Define INSN_PREFETCH_ERR_EN for per-word bus errors.
// Revision : 1.0
// =============================================================================
module insn_prefetch_buffer #(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [29:0] boot_addr_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        fetch_valid_o,
   input  logic        fetch_ready_i,
   output logic [31:0] fetch_rdata_o,
   output logic [31:0] fetch_addr_o,
`ifdef INSN_PREFETCH_ERR_EN
   output logic        fetch_err_o,
`endif
   output logic        busy_o,
   output logic        obi_req_o,
   input  logic        obi_gnt_i,
   output logic [31:0] obi_addr_o,
   output logic        obi_we_o,
   output logic [3:0]  obi_be_o,
   output logic [31:0] obi_wdata_o,
   input  logic        obi_rvalid_i,
`ifdef INSN_PREFETCH_ERR_EN
   input  logic        obi_err_i,
`endif
   output logic        obi_rready_o,
   input  logic [31:0] obi_rdata_i
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_AQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [c_AQ_W-1:0] c_AQ_LAST = c_AQ_W'(MAX_OUTSTANDING - 1);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_RUN   = 2'd1;
   localparam logic [1:0] c_ST_REDIR = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic               w_active;
   logic               w_stale;
   logic               w_room;
   logic               w_accept;
   logic               w_stall;
   logic               w_push;
   logic               w_pop;
   logic [29:0]        r_fetch_addr;
   logic [29:0]        r_redir_addr;
   logic [c_OUT_W-1:0] r_outstanding;
   logic [c_OUT_W-1:0] w_out_nxt;
   logic [c_OUT_W-1:0] r_discard;
   logic [c_OUT_W-1:0] w_disc_nxt;
   logic [29:0]        r_aq [MAX_OUTSTANDING];
   logic [c_AQ_W-1:0]  r_aq_wr;
   logic [c_AQ_W-1:0]  r_aq_rd;
   logic [31:0]        r_data [DEPTH];
   logic [29:0]        r_addr [DEPTH];
   logic [c_PTR_W-1:0] r_wr;
   logic [c_PTR_W-1:0] r_rd;
   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] w_count_nxt;
   logic               w_unused;

   assign w_unused = ^branch_addr_i[1:0];

   // Reserving a FIFO slot per outstanding request lets rready stay high.
   assign w_room = (32'(r_outstanding) < 32'(MAX_OUTSTANDING)) &&
                   ((32'(r_count) + 32'(r_outstanding)) < 32'(DEPTH));

   assign w_accept = obi_req_o && obi_gnt_i;
   assign w_stall  = obi_req_o && !obi_gnt_i;
   assign w_push   = obi_rvalid_i && (r_discard == '0) && !branch_i;
   assign w_pop    = fetch_valid_o && fetch_ready_i && !branch_i;

   // ---------------------------------------------------------------------------
   // Control FSM: IDLE loads the boot address, REDIR holds a stale request.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  w_state_nxt = c_ST_RUN;
         c_ST_RUN:   if (branch_i && w_stall) w_state_nxt = c_ST_REDIR;
         c_ST_REDIR: if (w_accept) w_state_nxt = c_ST_RUN;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   // The issue condition only relaxes while a request waits, so req never drops.
   always_comb begin
      w_active  = (r_state != c_ST_IDLE);
      w_stale   = (r_state == c_ST_REDIR);
      obi_req_o = w_active && w_room;
   end

   // ---------------------------------------------------------------------------
   // Fetch address and redirect target
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_fetch_addr <= '0;
         r_redir_addr <= '0;
      end else if (!w_active) begin
         r_fetch_addr <= boot_addr_i;
      end else if (branch_i && w_stall) begin
         r_redir_addr <= branch_addr_i[31:2];
      end else if (branch_i) begin
         r_fetch_addr <= branch_addr_i[31:2];
      end else if (w_accept) begin
         r_fetch_addr <= w_stale ? r_redir_addr : r_fetch_addr + 30'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outstanding and discard accounting
   // ---------------------------------------------------------------------------
   always_comb begin
      w_out_nxt = r_outstanding;
      if (w_accept && !obi_rvalid_i) begin
         w_out_nxt = r_outstanding + c_OUT_W'(1);
      end else if (!w_accept && obi_rvalid_i) begin
         w_out_nxt = r_outstanding - c_OUT_W'(1);
      end
   end

   // On redirect every transaction still in flight afterwards is stale.
   always_comb begin
      w_disc_nxt = r_discard;
      if (branch_i) begin
         w_disc_nxt = w_out_nxt;
      end else begin
         if (obi_rvalid_i && (r_discard != '0)) w_disc_nxt = w_disc_nxt - c_OUT_W'(1);
         if (w_accept && w_stale)               w_disc_nxt = w_disc_nxt + c_OUT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_out_nxt;
         r_discard     <= w_disc_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // In-flight address queue, popped by every response including dropped ones
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_aq_wr <= '0;
         r_aq_rd <= '0;
      end else begin
         if (w_accept)     r_aq_wr <= (r_aq_wr == c_AQ_LAST) ? '0 : r_aq_wr + c_AQ_W'(1);
         if (obi_rvalid_i) r_aq_rd <= (r_aq_rd == c_AQ_LAST) ? '0 : r_aq_rd + c_AQ_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept) r_aq[r_aq_wr] <= r_fetch_addr;
   end

   // ---------------------------------------------------------------------------
   // Response FIFO
   // ---------------------------------------------------------------------------
   always_comb begin
      w_count_nxt = r_count;
      if (branch_i) begin
         w_count_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_count_nxt = r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - c_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (branch_i) begin
            r_wr <= '0;
            r_rd <= '0;
         end else begin
            if (w_push) r_wr <= r_wr + c_PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + c_PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_data[r_wr] <= obi_rdata_i;
         r_addr[r_wr] <= r_aq[r_aq_rd];
      end
   end

`ifdef INSN_PREFETCH_ERR_EN
   logic r_err [DEPTH];

   always_ff @(posedge clk_i) begin
      if (w_push) r_err[r_wr] <= obi_err_i;
   end

   assign fetch_err_o = fetch_valid_o && r_err[r_rd];
`endif

   assign fetch_valid_o = (r_count != '0);
   assign fetch_rdata_o = r_data[r_rd];
   assign fetch_addr_o  = {r_addr[r_rd], 2'b00};
   assign busy_o        = (r_outstanding != '0) || (r_discard != '0);

   assign obi_addr_o   = {r_fetch_addr, 2'b00};
   assign obi_we_o     = 1'b0;
   assign obi_be_o     = 4'b1111;
   assign obi_wdata_o  = 32'h0;
   assign obi_rready_o = 1'b1;

endmodule
`default_nettype wire

// File: doc/insn_prefetch_buffer.md
Name: insn_prefetch_buffer

Overview:
Instruction prefetch buffer between the OBI instruction-memory port and the IF stage.
- Issues sequential word fetches ahead of the core and queues responses with their addresses in a FIFO.
- Flushes and redirects on control-flow changes.
- Discards responses to requests issued before the redirect, so IF only ever sees in-order, on-path words.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
MAX_OUTSTANDING, 2, max granted-but-unanswered OBI transactions; 1..DEPTH

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
boot_addr_i  in  30  word address fetched first after reset
branch_i  in  1  redirect request (jump/branch/trap/mret), single-cycle pulse
branch_addr_i  in  32  redirect target; bits [1:0] ignored
fetch_valid_o  out  1  FIFO head valid
fetch_ready_i  in  1  IF consumes head when valid&ready
fetch_rdata_o  out  32  head instruction word
fetch_addr_o  out  32  head word address, [1:0]=0
busy_o  out  1  outstanding transactions or discards pending
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  32  OBI address, [1:0]=0
obi_we_o  out  1  constant 0
obi_be_o  out  4  constant 4'b1111
obi_wdata_o  out  32  constant 0
obi_rvalid_i  in  1  OBI response valid
obi_rready_o  out  1  constant 1
obi_rdata_i  in  32  OBI read data

Behaviour:
Reset values:
- fetch_valid_o=0, obi_req_o=0, busy_o=0.
- FIFO empty; outstanding=0, discard=0.
- next fetch address = {boot_addr_i,2'b0}.
- An "active" flop sets on the first clock after reset release; obi_req_o is gated by it.

Issue:
- Condition: active && outstanding < MAX_OUTSTANDING && (fifo_count + outstanding) < DEPTH.
- Slot reservation at issue guarantees FIFO space for every response, hence obi_rready_o=1.

OBI stability:
- Once obi_req_o=1 without gnt, req and addr stay stable until obi_gnt_i, regardless of branch_i, FIFO pops or reset-free events.

Counters:
- Accept = req&gnt: outstanding+1, next fetch address += 4.
- 32-bit wrap 0xFFFFFFFC -> 0x00000000 is legal.
- outstanding-1 on obi_rvalid_i. Accept and rvalid in the same cycle leave it unchanged.

Write:
- obi_rvalid_i && discard==0 pushes {rdata, addr}; addr comes from an in-flight address queue of depth MAX_OUTSTANDING.
- obi_rvalid_i && discard>0 drops the word; discard-1.

Pop:
- fetch_valid_o = !empty. Head is registered: a response is visible on the cycle after rvalid, with no bypass.
- Push and pop in the same cycle at full or empty behave correctly; count is unchanged.

Redirect (branch_i=1), all effects at the clock edge:
- FIFO cleared; fetch_valid_o=0 next cycle; a simultaneous pop and push are ignored.
- discard <= outstanding + (req&gnt this cycle) - (rvalid this cycle), where a same-cycle rvalid is treated as dropped.
- Next fetch address <= {branch_addr_i[31:2],2'b00}.
- If a request is pending ungranted, it completes with its old address and is then counted into discard. The redirect target is held in a pending register and issued next.
- Back-to-back branch_i: last target wins; discard accumulates correctly.

busy_o = (outstanding != 0) || (discard != 0).

Reset mid-operation: all state returns to reset values immediately; late rvalids after reset are a bench error, not handled.

Optional Feature:
INSN_PREFETCH_ERR_EN
- Defined:
  - Adds obi_err_i (in, 1, qualified by obi_rvalid_i) and fetch_err_o (out, 1, reset 0).
  - The error bit is stored per FIFO entry and presented with the head.
  - Discarded responses drop their error.
  - Errored entries still pop normally; prefetching continues.
- Undefined: ports absent, no error storage.

Test Plan:
1. Reset with boot_addr_i=30'h0000_0020, gnt/rvalid 1-cycle latency, ready=1 -> OBI addresses 0x80,0x84,0x88…; fetch_addr_o follows in order with rdata matching; first fetch_valid_o exactly 2 cycles after first gnt.
2. fetch_ready_i=0, memory always granting -> exactly DEPTH=4 accepts, then obi_req_o=0 while fifo_count=4; one pop re-enables exactly one request.
3. Two transactions outstanding, branch_i with branch_addr_i=0x0000_1002 -> both following rvalids dropped (busy_o=1 until last), next OBI addr 0x1000, first fetch_addr_o after redirect 0x1000.
4. obi_req_o=1 with gnt held low 3 cycles, branch_i pulsed in cycle 1 to 0x200 -> obi_addr_o stable at old address until gnt, that response discarded, then request to 0x200.
5. Next fetch address 0xFFFF_FFFC -> following request 0x0000_0000; simultaneous pop+push at FIFO full keeps fetch_valid_o=1 and order intact.
6. With INSN_PREFETCH_ERR_EN: rvalid with obi_err_i=1 at 0x40 -> fetch_err_o=1 only while head address is 0x40; error on a discarded response never appears.
